// File: rtl/mandel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mandel_pkg : state encoding and fixed-point constant helpers for the        |
// |              Mandelbrot escape-time iterator                                |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
package mandel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SQ_R   = 3'd1,
        ST_SQ_I   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Fixed-point encodings of 4.0 and 2.0, masked to the datapath width.
    function automatic logic [63:0] fx_four(input int w, input int frac);
        return (64'd4 << frac) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] fx_two(input int w, input int frac);
        return (64'd2 << frac) & ((64'd1 << w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mandel_fx_mult.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mandel_fx_mult : combinational signed fixed-point multiplier, truncating    |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module mandel_fx_mult #(
    parameter int W    = 27,
    parameter int FRAC = 23
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] p_o
);

    logic w_neg;

    // The full 2W-bit product never overflows, so its sign is the true product sign.
    assign w_neg = (a_i[W-1] ^ b_i[W-1]) & (|a_i) & (|b_i);
    assign p_o   = {w_neg, (W-1)'(((2*W)'(a_i) * (2*W)'(b_i)) >>> FRAC)};

endmodule
`default_nettype wire

// File: rtl/mandel_iter_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mandel_iter_param : parametrised Mandelbrot escape-time iterator with       |
// |                     per-point limit and 1- or 3-multiplier datapath         |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
module mandel_iter_param
    import mandel_pkg::*;
#(
    parameter int W      = 27,
    parameter int FRAC   = 23,
    parameter int ITER_W = 10,
    parameter int N_MULT = 1,
    parameter int TAG_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [W-1:0]      in_c_r,
    input  logic [W-1:0]      in_c_i,
    input  logic [ITER_W-1:0] in_max_iter,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam logic signed [W-1:0] C_FOUR    = W'(fx_four(W, FRAC));
    localparam logic signed [W:0]   C_TWO     = (W+1)'(fx_two(W, FRAC));
    localparam state_e              C_ITER_ST = (N_MULT == 1) ? ST_SQ_R : ST_UPDATE;

    state_e              state_q;
    logic signed [W-1:0] zr_q, zi_q, cr_q, ci_q;
    logic [ITER_W-1:0]   max_q, cnt_q;
    logic [TAG_W-1:0]    tag_q;
    logic                out_val_q, out_esc_q;
    logic [ITER_W-1:0]   out_iter_q;
    logic [TAG_W-1:0]    out_tag_q;

    logic signed [W-1:0] w_sq_r, w_sq_i, w_cross;

    generate
        if (N_MULT == 1) begin : g_seq
            logic signed [W-1:0] mul_a, mul_b, prod, sqr_q, sqi_q;

            // One multiplier walks zr*zr, zi*zi, zr*zi across the three states.
            always_comb begin
                mul_a = zr_q;
                mul_b = zr_q;
                if (state_q == ST_SQ_I) begin
                    mul_a = zi_q;
                    mul_b = zi_q;
                end else if (state_q == ST_UPDATE) begin
                    mul_b = zi_q;
                end
            end

            mandel_fx_mult #(.W(W), .FRAC(FRAC)) u_mult (.a_i(mul_a), .b_i(mul_b), .p_o(prod));

            always_ff @(posedge clk) begin
                if (reset) begin
                    sqr_q <= '0;
                    sqi_q <= '0;
                end else begin
                    if (state_q == ST_SQ_R) sqr_q <= prod;
                    if (state_q == ST_SQ_I) sqi_q <= prod;
                end
            end

            assign w_sq_r  = sqr_q;
            assign w_sq_i  = sqi_q;
            assign w_cross = prod;
        end else if (N_MULT == 3) begin : g_par
            mandel_fx_mult #(.W(W), .FRAC(FRAC)) u_mult_rr (.a_i(zr_q), .b_i(zr_q), .p_o(w_sq_r));
            mandel_fx_mult #(.W(W), .FRAC(FRAC)) u_mult_ii (.a_i(zi_q), .b_i(zi_q), .p_o(w_sq_i));
            mandel_fx_mult #(.W(W), .FRAC(FRAC)) u_mult_ri (.a_i(zr_q), .b_i(zi_q), .p_o(w_cross));
        end else begin : g_bad
            $error("mandel_iter_param: N_MULT must be 1 or 3");
        end
    endgenerate

    logic signed [W-1:0] w_sum, w_zr_d, w_zi_d;
    logic signed [W:0]   w_zr_x, w_zi_x, w_abs_r, w_abs_i;
    logic                w_escape;

    assign w_sum    = w_sq_r + w_sq_i;
    assign w_zr_x   = {zr_q[W-1], zr_q};
    assign w_zi_x   = {zi_q[W-1], zi_q};
    assign w_abs_r  = w_zr_x[W] ? -w_zr_x : w_zr_x;
    assign w_abs_i  = w_zi_x[W] ? -w_zi_x : w_zi_x;
    // A wrapped (negative) sum of squares means the magnitude has already blown up.
    assign w_escape = (w_sum > C_FOUR) | w_sum[W-1] | (w_abs_r > C_TWO) | (w_abs_i > C_TWO);
    assign w_zr_d   = w_sq_r - w_sq_i + cr_q;
    assign w_zi_d   = (w_cross <<< 1) + ci_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            zr_q       <= '0;
            zi_q       <= '0;
            cr_q       <= '0;
            ci_q       <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
            out_val_q  <= 1'b0;
            out_esc_q  <= 1'b0;
            out_iter_q <= '0;
            out_tag_q  <= '0;
        end else if (flush && (state_q != ST_IDLE)) begin
            state_q   <= ST_IDLE;
            out_val_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_val) begin
                        cr_q    <= in_c_r;
                        ci_q    <= in_c_i;
                        max_q   <= in_max_iter;
                        tag_q   <= in_tag;
                        zr_q    <= '0;
                        zi_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= C_ITER_ST;
                    end
                end
                ST_SQ_R: state_q <= ST_SQ_I;
                ST_SQ_I: state_q <= ST_UPDATE;
                ST_UPDATE: begin
                    if (w_escape || (cnt_q == max_q)) begin
                        out_iter_q <= cnt_q;
                        out_esc_q  <= w_escape;
                        out_tag_q  <= tag_q;
                        out_val_q  <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        zr_q    <= w_zr_d;
                        zi_q    <= w_zi_d;
                        cnt_q   <= cnt_q + ITER_W'(1);
                        state_q <= C_ITER_ST;
                    end
                end
                ST_DONE: begin
                    if (out_rdy) begin
                        out_val_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_rdy      = ~reset & (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_val     = out_val_q;
    assign out_iter    = out_iter_q;
    assign out_escaped = out_esc_q;
    assign out_tag     = out_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_mandel_iter_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mandel_iter_param : scoreboard bench, one sequenced and one parallel DUT |
// | Revision             : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_mandel_iter_param;

    localparam int W1 = 27, F1 = 23, W3 = 18, F3 = 14, IW = 10, TW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          reset1 = 1'b1, flush1 = 1'b0, in_val1 = 1'b0, out_rdy1 = 1'b1;
    logic [W1-1:0] in_cr1 = '0, in_ci1 = '0;
    logic [IW-1:0] in_max1 = '0;
    logic [TW-1:0] in_tag1 = '0;
    logic          in_rdy1, out_val1, out_esc1, busy1;
    logic [IW-1:0] out_iter1;
    logic [TW-1:0] out_tag1;

    logic          reset3 = 1'b1, flush3 = 1'b0, in_val3 = 1'b0, out_rdy3 = 1'b1;
    logic [W3-1:0] in_cr3 = '0, in_ci3 = '0;
    logic [IW-1:0] in_max3 = '0;
    logic [TW-1:0] in_tag3 = '0;
    logic          in_rdy3, out_val3, out_esc3, busy3;
    logic [IW-1:0] out_iter3;
    logic [TW-1:0] out_tag3;

    mandel_iter_param #(.W(W1), .FRAC(F1), .ITER_W(IW), .N_MULT(1), .TAG_W(TW)) dut1 (
        .clk(clk), .reset(reset1), .flush(flush1), .in_val(in_val1), .in_rdy(in_rdy1),
        .in_c_r(in_cr1), .in_c_i(in_ci1), .in_max_iter(in_max1), .in_tag(in_tag1),
        .out_val(out_val1), .out_rdy(out_rdy1), .out_iter(out_iter1),
        .out_escaped(out_esc1), .out_tag(out_tag1), .busy(busy1));

    mandel_iter_param #(.W(W3), .FRAC(F3), .ITER_W(IW), .N_MULT(3), .TAG_W(TW)) dut3 (
        .clk(clk), .reset(reset3), .flush(flush3), .in_val(in_val3), .in_rdy(in_rdy3),
        .in_c_r(in_cr3), .in_c_i(in_ci3), .in_max_iter(in_max3), .in_tag(in_tag3),
        .out_val(out_val3), .out_rdy(out_rdy3), .out_iter(out_iter3),
        .out_escaped(out_esc3), .out_tag(out_tag3), .busy(busy3));

    typedef struct {int n; bit esc; int tag; int t;} exp_t;
    exp_t q1[$];
    exp_t q3[$];
    int   n_vec = 0, n_err = 0;
    bit   bp1 = 1'b0, bp3 = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: two's-complement wrap and truncating fixed-point multiply in plain arithmetic.
    function automatic longint wrapw(input longint x, input int w);
        longint m = longint'(1) << w;
        longint r = x & (m - 1);
        if (r >= (m >>> 1)) r = r - m;
        return r;
    endfunction

    function automatic longint fmul(input longint a, input longint b, input int w, input int fr);
        longint p = a * b;
        longint h = longint'(1) << (w - 1);
        longint r = (p >>> fr) & (h - 1);
        if (p < 0) r = r - h;
        return r;
    endfunction

    function automatic void model(input longint cr, input longint ci, input int mx, input int w,
                                  input int fr, output int n, output bit esc);
        longint zr = 0, zi = 0, sr, si, x, sum;
        longint four = longint'(4) << fr;
        longint two  = longint'(2) << fr;
        n = 0;
        esc = 1'b0;
        for (int k = 0; k <= mx; k++) begin
            sr  = fmul(zr, zr, w, fr);
            si  = fmul(zi, zi, w, fr);
            x   = fmul(zr, zi, w, fr);
            sum = wrapw(sr + si, w);
            if (sum > four || sum < 0 || (zr < 0 ? -zr : zr) > two || (zi < 0 ? -zi : zi) > two) begin
                n = k;
                esc = 1'b1;
                return;
            end
            if (k == mx) begin
                n = k;
                return;
            end
            zr = wrapw(sr - si + cr, w);
            zi = wrapw(2 * x + ci, w);
        end
    endfunction

    task automatic send(input bit d3, input longint cr, input longint ci, input int mx, input int tg,
                        input bit push, input int en, input bit ee, output int t);
        @(posedge clk); #1;
        if (d3) begin
            in_cr3 = cr[W3-1:0]; in_ci3 = ci[W3-1:0]; in_max3 = IW'(mx); in_tag3 = TW'(tg); in_val3 = 1'b1;
        end else begin
            in_cr1 = cr[W1-1:0]; in_ci1 = ci[W1-1:0]; in_max1 = IW'(mx); in_tag1 = TW'(tg); in_val1 = 1'b1;
        end
        t = -1;
        for (int g = 0; g < 5000; g++) begin
            @(negedge clk);
            if ((d3 ? in_rdy3 : in_rdy1) == 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_rdy stayed 0, dut %0d tag %0h", d3 ? 3 : 1, tg);
        end else if (push) begin
            if (d3) q3.push_back('{en, ee, tg, t});
            else    q1.push_back('{en, ee, tg, t});
        end
        @(posedge clk); #1;
        in_val1 = 1'b0;
        in_val3 = 1'b0;
    endtask

    task automatic send_model(input bit d3, input longint cr, input longint ci, input int mx, input int tg);
        int n, t;
        bit e;
        model(cr, ci, mx, d3 ? W3 : W1, d3 ? F3 : F1, n, e);
        send(d3, cr, ci, mx, tg, 1'b1, n, e, t);
    endtask

    task automatic drain(input bit d3);
        bit ok = 1'b0;
        for (int g = 0; g < 20000; g++) begin
            @(negedge clk);
            if ((d3 ? q3.size() : q1.size()) == 0 && (d3 ? in_rdy3 : in_rdy1) == 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: dut %0d still has %0d results pending", d3 ? 3 : 1,
                     d3 ? q3.size() : q1.size());
        end
    endtask

    // Monitors: check latency on out_val rise, stability while stalled, contents on handshake.
    bit            prev1 = 1'b0, prev3 = 1'b0;
    logic [IW-1:0] h_iter1, h_iter3;
    logic [TW-1:0] h_tag1, h_tag3;
    logic          h_esc1, h_esc3;
    exp_t          e1, e3;

    initial forever begin
        @(negedge clk);
        if (reset1) prev1 = 1'b0;
        else begin
            if (out_val1) begin
                chk("in_rdy_during_out_val1", in_rdy1, 0);
                if (!prev1) begin
                    h_iter1 = out_iter1; h_tag1 = out_tag1; h_esc1 = out_esc1;
                    if (q1.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_out1: out_val with no point pending, tag %0h", out_tag1);
                    end else chk("latency1", cyc - q1[0].t, 3 * (q1[0].n + 1) + 1);
                end else begin
                    chk("stable_iter1", out_iter1, h_iter1);
                    chk("stable_tag1", out_tag1, h_tag1);
                    chk("stable_esc1", out_esc1, h_esc1);
                end
                if (out_rdy1 && q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("iter1", out_iter1, e1.n);
                    chk("escaped1", out_esc1, e1.esc);
                    chk("tag1", out_tag1, e1.tag);
                end
            end
            prev1 = out_val1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset3) prev3 = 1'b0;
        else begin
            if (out_val3) begin
                chk("in_rdy_during_out_val3", in_rdy3, 0);
                if (!prev3) begin
                    h_iter3 = out_iter3; h_tag3 = out_tag3; h_esc3 = out_esc3;
                    if (q3.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_out3: out_val with no point pending, tag %0h", out_tag3);
                    end else chk("latency3", cyc - q3[0].t, q3[0].n + 2);
                end else begin
                    chk("stable_iter3", out_iter3, h_iter3);
                    chk("stable_tag3", out_tag3, h_tag3);
                    chk("stable_esc3", out_esc3, h_esc3);
                end
                if (out_rdy3 && q3.size() != 0) begin
                    e3 = q3.pop_front();
                    chk("iter3", out_iter3, e3.n);
                    chk("escaped3", out_esc3, e3.esc);
                    chk("tag3", out_tag3, e3.tag);
                end
            end
            prev3 = out_val3;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (bp1) out_rdy1 = ($urandom_range(0, 3) != 0);
        if (bp3) out_rdy3 = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam longint ONE1 = longint'(1) << F1;
    localparam longint R1   = longint'(5) << (F1 - 1);
    localparam longint R3   = longint'(5) << (F3 - 1);

    initial begin
        int t;

        repeat (3) @(negedge clk);
        chk("in_rdy_in_reset1", in_rdy1, 0);
        chk("in_rdy_in_reset3", in_rdy3, 0);
        @(posedge clk); #1;
        reset1 = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);
        chk("rst_out_val1", out_val1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_in_rdy1", in_rdy1, 1);
        chk("rst_out_iter1", out_iter1, 0);
        chk("rst_out_esc1", out_esc1, 0);
        chk("rst_out_tag1", out_tag1, 0);
        chk("rst_out_val3", out_val3, 0);
        chk("rst_in_rdy3", in_rdy3, 1);

        // Directed points with hand-derived results
        send(0, 0, 0, 100, 16'h1234, 1, 100, 0, t);
        send(0, 2 * ONE1, 0, 100, 16'h0002, 1, 2, 1, t);
        send(0, -2 * ONE1, 0, 50, 16'h00F2, 1, 50, 0, t);
        send(0, 66270003, 66270003, 100, 16'h0079, 1, 1, 1, t);
        send(0, ONE1 / 2, ONE1 / 2, 0, 16'h0000, 1, 0, 0, t);
        send(0, 0, 0, 1023, 16'hFFFF, 1, 1023, 0, t);
        drain(0);

        // Output held under back-pressure
        @(posedge clk); #1;
        out_rdy1 = 1'b0;
        send_model(0, ONE1 / 4, 0, 10, 16'h0BEE);
        for (int g = 0; g < 200 && !out_val1; g++) @(negedge clk);
        chk("t4_out_val_seen", out_val1, 1);
        repeat (20) begin
            @(negedge clk);
            chk("t4_hold_out_val", out_val1, 1);
            chk("t4_hold_in_rdy", in_rdy1, 0);
            chk("t4_hold_tag", out_tag1, 16'h0BEE);
        end
        @(posedge clk); #1;
        out_rdy1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_in_rdy_after", in_rdy1, 1);
        chk("t4_out_val_after", out_val1, 0);
        chk("t4_tag_kept", out_tag1, 16'h0BEE);
        chk("t4_busy_after", busy1, 0);

        // Flush at SQ_I of iteration 5
        send(0, 0, 0, 100, 16'h5555, 0, 0, 0, t);
        while (cyc < t + 17) begin @(posedge clk); #1; end
        flush1 = 1'b1;
        @(posedge clk); #1;
        flush1 = 1'b0;
        @(negedge clk);
        chk("t5_flush_in_rdy", in_rdy1, 1);
        chk("t5_flush_busy", busy1, 0);
        chk("t5_flush_out_val", out_val1, 0);
        repeat (5) @(negedge clk);
        chk("t5_flush_quiet", busy1, 0);

        // Reset at the same point
        send(0, 0, 0, 100, 16'h6666, 0, 0, 0, t);
        while (cyc < t + 17) begin @(posedge clk); #1; end
        reset1 = 1'b1;
        @(posedge clk); #1;
        reset1 = 1'b0;
        @(negedge clk);
        chk("t5_reset_in_rdy", in_rdy1, 1);
        chk("t5_reset_busy", busy1, 0);
        chk("t5_reset_out_tag", out_tag1, 0);
        chk("t5_reset_out_iter", out_iter1, 0);
        send_model(0, ONE1 / 4, ONE1 / 2, 64, 16'h0C25);
        drain(0);

        // Random points with random back-pressure, sequenced datapath
        bp1 = 1'b1;
        for (int i = 0; i < 16; i++)
            send_model(0, longint'($urandom_range(0, 2 * R1)) - R1, longint'($urandom_range(0, 2 * R1)) - R1,
                       int'($urandom_range(0, 60)), int'($urandom_range(0, 65535)));
        bp1 = 1'b0;
        @(posedge clk); #2;
        out_rdy1 = 1'b1;
        drain(0);

        // Parallel datapath, narrower format
        bp3 = 1'b1;
        for (int i = 0; i < 64; i++)
            send_model(1, longint'($urandom_range(0, 2 * R3)) - R3, longint'($urandom_range(0, 2 * R3)) - R3,
                       int'($urandom_range(0, 40)), int'($urandom_range(0, 65535)));
        bp3 = 1'b0;
        @(posedge clk); #2;
        out_rdy3 = 1'b1;
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
